// File: rtl/mips_exec_ctrl.sv
// mips_exec_ctrl -- multi-cycle MIPS execution controller with integrated ALU.
// Sequences HALT -> FETCH -> DECODE -> EXEC1 -> EXEC2 -> FETCH, advancing only
// on edges where the Avalon waitrequest is low, and decodes the current
// instruction into bus strobes, byte lanes, register-file controls and an ALU
// result.
// Ports:
//   clk, reset (async, active-low), waitrequest      - clock, reset, bus stall
//   instr, rs_data, rt_data                          - instruction and operands
//   state                                            - current sequencer state
//   mem_read, mem_write, byteenable, pc_to_addr      - Avalon bus controls
//   ir_write, pc_write, reg_write                    - write enables (stall-gated)
//   reg_dst, link, mem_to_reg, ext_op                - write-back steering
//   branch, jump, reg_to_jump                        - control-flow indicators
//   alu_result, zero                                 - ALU output and flag
module mips_exec_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        waitrequest,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [2:0]  state,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  byteenable,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        pc_to_addr,
  output logic        reg_dst,
  output logic        link,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        reg_to_jump,
  output logic [2:0]  ext_op,
  output logic [31:0] alu_result,
  output logic        zero
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [5:0]  opcode_s, funct_s;
  logic [4:0]  rt_f_s, shamt_s;
  logic [31:0] imm_se_s, imm_ze_s, res_s;
  logic        taken_s, load_s, store_s, regw_s, dst_s, link_s, m2r_s;
  logic        branch_s, jump_s, rjump_s, r_alu_s;
  logic [1:0]  size_s;
  logic [2:0]  ext_s;
  logic [3:0]  lanes_s;

  assign opcode_s = instr[31:26];
  assign rt_f_s   = instr[20:16];
  assign shamt_s  = instr[10:6];
  assign funct_s  = instr[5:0];
  assign imm_se_s = {{16{instr[15]}}, instr[15:0]};
  assign imm_ze_s = {16'd0, instr[15:0]};

  // State register: async reset to HALT, otherwise load next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_HALT;
    else        state_q <= state_d;
  end

  // Next-state logic: a stalled bus freezes the sequencer.
  always_comb begin
    state_d = state_q;
    if (waitrequest) begin
      state_d = state_q;
    end else begin
      case (state_q)
        S_HALT:   state_d = S_FETCH;
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: state_d = S_EXEC1;
        S_EXEC1:  state_d = S_EXEC2;
        S_EXEC2:  state_d = S_FETCH;
        default:  state_d = S_HALT;
      endcase
    end
  end

  // Instruction decode and ALU; unrecognised encodings leave every control at 0.
  always_comb begin
    res_s = 32'd0; taken_s = 1'b0; load_s = 1'b0; store_s = 1'b0;
    regw_s = 1'b0; dst_s = 1'b0; link_s = 1'b0; m2r_s = 1'b0;
    branch_s = 1'b0; jump_s = 1'b0; rjump_s = 1'b0; r_alu_s = 1'b0;
    size_s = 2'd2; ext_s = 3'b000;
    case (opcode_s)
      6'h00: begin
        r_alu_s = 1'b1;
        case (funct_s)
          6'h00: res_s = rt_data << shamt_s;
          6'h02: res_s = rt_data >> shamt_s;
          6'h03: res_s = $signed(rt_data) >>> shamt_s;
          6'h04: res_s = rt_data << rs_data[4:0];
          6'h06: res_s = rt_data >> rs_data[4:0];
          6'h07: res_s = $signed(rt_data) >>> rs_data[4:0];
          6'h08: begin res_s = rs_data; rjump_s = 1'b1; r_alu_s = 1'b0; end
          6'h09: begin res_s = rs_data; rjump_s = 1'b1; end
          6'h21: res_s = rs_data + rt_data;
          6'h23: res_s = rs_data - rt_data;
          6'h24: res_s = rs_data & rt_data;
          6'h25: res_s = rs_data | rt_data;
          6'h26: res_s = rs_data ^ rt_data;
          6'h27: res_s = ~(rs_data | rt_data);
          6'h2A: res_s = {31'd0, $signed(rs_data) < $signed(rt_data)};
          6'h2B: res_s = {31'd0, rs_data < rt_data};
          default: r_alu_s = 1'b0;
        endcase
        regw_s = r_alu_s;
        dst_s  = r_alu_s;
      end
      6'h01: begin
        res_s = rs_data;
        case (rt_f_s)
          5'h00: begin branch_s = 1'b1; taken_s = rs_data[31]; end
          5'h01: begin branch_s = 1'b1; taken_s = ~rs_data[31]; end
          5'h10: begin branch_s = 1'b1; taken_s = rs_data[31]; link_s = 1'b1; end
          5'h11: begin branch_s = 1'b1; taken_s = ~rs_data[31]; link_s = 1'b1; end
          default: branch_s = 1'b0;
        endcase
        regw_s = link_s;
      end
      6'h02: jump_s = 1'b1;
      6'h03: begin jump_s = 1'b1; link_s = 1'b1; regw_s = 1'b1; end
      6'h04: begin res_s = rs_data - rt_data; branch_s = 1'b1; taken_s = (rs_data == rt_data); end
      6'h05: begin res_s = rs_data - rt_data; branch_s = 1'b1; taken_s = (rs_data != rt_data); end
      6'h06: begin res_s = rs_data; branch_s = 1'b1; taken_s = rs_data[31] | (rs_data == 32'd0); end
      6'h07: begin res_s = rs_data; branch_s = 1'b1; taken_s = ~rs_data[31] & (rs_data != 32'd0); end
      6'h09: begin res_s = rs_data + imm_se_s; regw_s = 1'b1; end
      6'h0A: begin res_s = {31'd0, $signed(rs_data) < $signed(imm_se_s)}; regw_s = 1'b1; end
      6'h0B: begin res_s = {31'd0, rs_data < imm_se_s}; regw_s = 1'b1; end
      6'h0C: begin res_s = rs_data & imm_ze_s; regw_s = 1'b1; end
      6'h0D: begin res_s = rs_data | imm_ze_s; regw_s = 1'b1; end
      6'h0E: begin res_s = rs_data ^ imm_ze_s; regw_s = 1'b1; end
      6'h0F: begin res_s = {instr[15:0], 16'd0}; regw_s = 1'b1; end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        res_s = rs_data + imm_se_s; load_s = 1'b1; regw_s = 1'b1;
        case (opcode_s)
          6'h20: begin size_s = 2'd0; ext_s = 3'b111; end
          6'h21: begin size_s = 2'd1; ext_s = 3'b101; end
          6'h22: ext_s = 3'b001;
          6'h24: begin size_s = 2'd0; ext_s = 3'b110; end
          6'h25: begin size_s = 2'd1; ext_s = 3'b100; end
          6'h26: ext_s = 3'b010;
          default: m2r_s = 1'b1;  // LW: full word, no extension
        endcase
      end
      6'h28: begin res_s = rs_data + imm_se_s; store_s = 1'b1; size_s = 2'd0; end
      6'h29: begin res_s = rs_data + imm_se_s; store_s = 1'b1; size_s = 2'd1; end
      6'h2B: begin res_s = rs_data + imm_se_s; store_s = 1'b1; end
      default: res_s = 32'd0;
    endcase
  end

  // Byte-lane selection from the low address bits and access size.
  always_comb begin
    lanes_s = 4'b0000;
    if (load_s | store_s) begin
      case (size_s)
        2'd0:    lanes_s = 4'b0001 << res_s[1:0];
        2'd1:    lanes_s = res_s[1] ? 4'b1100 : 4'b0011;
        default: lanes_s = 4'b1111;
      endcase
    end else begin
      lanes_s = 4'b0000;
    end
  end

  // Per-state strobes; write enables are suppressed while the bus stalls.
  always_comb begin
    mem_read = 1'b0; mem_write = 1'b0; byteenable = 4'b0000; ir_write = 1'b0;
    pc_write = 1'b0; reg_write = 1'b0; pc_to_addr = 1'b0;
    case (state_q)
      S_FETCH: begin pc_to_addr = 1'b1; mem_read = 1'b1; byteenable = 4'b1111; end
      S_DECODE: ir_write = ~waitrequest;
      S_EXEC1: begin
        if (store_s) begin mem_write = 1'b1; byteenable = lanes_s; end
        else         begin mem_write = 1'b0; end
      end
      S_EXEC2: begin
        pc_write  = ~waitrequest;
        reg_write = regw_s & ~waitrequest;
        if (load_s) begin mem_read = 1'b1; byteenable = lanes_s; end
        else        begin mem_read = 1'b0; end
      end
      default: mem_read = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign reg_dst     = dst_s;
  assign link        = link_s;
  assign mem_to_reg  = m2r_s;
  assign branch      = branch_s;
  assign jump        = jump_s;
  assign reg_to_jump = rjump_s;
  assign ext_op      = ext_s;
  assign alu_result  = res_s;
  // For branches zero carries the taken decision rather than a zero test.
  assign zero        = branch_s ? taken_s : (res_s == 32'd0);

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Testbench for mips_exec_ctrl: directed ALU table, hand-written multi-cycle
// sequences, and randomized instructions checked against a mnemonic-level model.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset, waitrequest;
  logic [31:0] instr, rs_data, rt_data;
  logic [2:0]  state;
  logic        mem_read, mem_write, ir_write, pc_write, reg_write, pc_to_addr;
  logic        reg_dst, link, mem_to_reg, branch, jump, reg_to_jump, zero;
  logic [3:0]  byteenable;
  logic [2:0]  ext_op;
  logic [31:0] alu_result;

  mips_exec_ctrl dut (
    .clk(clk), .reset(reset), .waitrequest(waitrequest), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data), .state(state), .mem_read(mem_read),
    .mem_write(mem_write), .byteenable(byteenable), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .pc_to_addr(pc_to_addr),
    .reg_dst(reg_dst), .link(link), .mem_to_reg(mem_to_reg), .branch(branch),
    .jump(jump), .reg_to_jump(reg_to_jump), .ext_op(ext_op),
    .alu_result(alu_result), .zero(zero)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  int    exp_st = 0;
  string cur_tag = "init";

  typedef enum int {
    M_BAD, M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR, M_ADDU,
    M_SUBU, M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_BLTZ, M_BGEZ, M_BLTZAL,
    M_BGEZAL, M_J, M_JAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_ADDIU, M_SLTI, M_SLTIU,
    M_ANDI, M_ORI, M_XORI, M_LUI, M_LB, M_LH, M_LWL, M_LW, M_LBU, M_LHU, M_LWR,
    M_SB, M_SH, M_SW
  } mn_e;

  typedef struct packed {
    logic [31:0] res;
    logic        res_chk, zero, zero_chk, ld, st, wr_reg, dst, lnk, m2r, br, jmp, rjmp;
    logic [2:0]  ext;
    logic [3:0]  lanes;
  } exp_t;

  function automatic mn_e classify(input logic [31:0] i);
    mn_e m;
    m = M_BAD;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h00: m = M_SLL;  6'h02: m = M_SRL;  6'h03: m = M_SRA;  6'h04: m = M_SLLV;
        6'h06: m = M_SRLV; 6'h07: m = M_SRAV; 6'h08: m = M_JR;   6'h09: m = M_JALR;
        6'h21: m = M_ADDU; 6'h23: m = M_SUBU; 6'h24: m = M_AND;  6'h25: m = M_OR;
        6'h26: m = M_XOR;  6'h27: m = M_NOR;  6'h2A: m = M_SLT;  6'h2B: m = M_SLTU;
        default: m = M_BAD;
      endcase
      6'h01: case (i[20:16])
        5'h00: m = M_BLTZ; 5'h01: m = M_BGEZ; 5'h10: m = M_BLTZAL; 5'h11: m = M_BGEZAL;
        default: m = M_BAD;
      endcase
      6'h02: m = M_J;     6'h03: m = M_JAL;   6'h04: m = M_BEQ;   6'h05: m = M_BNE;
      6'h06: m = M_BLEZ;  6'h07: m = M_BGTZ;  6'h09: m = M_ADDIU; 6'h0A: m = M_SLTI;
      6'h0B: m = M_SLTIU; 6'h0C: m = M_ANDI;  6'h0D: m = M_ORI;   6'h0E: m = M_XORI;
      6'h0F: m = M_LUI;   6'h20: m = M_LB;    6'h21: m = M_LH;    6'h22: m = M_LWL;
      6'h23: m = M_LW;    6'h24: m = M_LBU;   6'h25: m = M_LHU;   6'h26: m = M_LWR;
      6'h28: m = M_SB;    6'h29: m = M_SH;    6'h2B: m = M_SW;
      default: m = M_BAD;
    endcase
    return m;
  endfunction

  // Reference: results and controls computed from the instruction's meaning.
  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    mn_e m;
    logic [31:0] se, ze;
    logic [4:0]  sh, va;
    longint sa, sb, sse;
    e = '0;
    m = classify(i);
    se = {{16{i[15]}}, i[15:0]};
    ze = {16'd0, i[15:0]};
    sh = i[10:6];
    va = a[4:0];
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sse = longint'($signed(se));
    e.res_chk = 1'b1;
    case (m)
      M_SLL:   e.res = b << sh;
      M_SRL:   e.res = b >> sh;
      M_SRA:   e.res = 32'(sb >>> sh);
      M_SLLV:  e.res = b << va;
      M_SRLV:  e.res = b >> va;
      M_SRAV:  e.res = 32'(sb >>> va);
      M_ADDU:  e.res = 32'(longint'(a) + longint'(b));
      M_SUBU:  e.res = 32'(longint'(a) - longint'(b));
      M_AND:   e.res = a & b;
      M_OR:    e.res = a | b;
      M_XOR:   e.res = a ^ b;
      M_NOR:   e.res = ~(a | b);
      M_SLT:   e.res = (sa < sb) ? 32'd1 : 32'd0;
      M_SLTU:  e.res = (a < b) ? 32'd1 : 32'd0;
      M_ADDIU: e.res = 32'(sa + sse);
      M_SLTI:  e.res = (sa < sse) ? 32'd1 : 32'd0;
      M_SLTIU: e.res = (a < se) ? 32'd1 : 32'd0;
      M_ANDI:  e.res = a & ze;
      M_ORI:   e.res = a | ze;
      M_XORI:  e.res = a ^ ze;
      M_LUI:   e.res = ze * 32'd65536;
      M_LB, M_LH, M_LWL, M_LW, M_LBU, M_LHU, M_LWR, M_SB, M_SH, M_SW:
               e.res = 32'(sa + sse);
      default: e.res_chk = 1'b0;
    endcase
    e.ld   = m inside {M_LB, M_LH, M_LWL, M_LW, M_LBU, M_LHU, M_LWR};
    e.st   = m inside {M_SB, M_SH, M_SW};
    e.br   = m inside {M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL, M_BEQ, M_BNE, M_BLEZ, M_BGTZ};
    e.jmp  = m inside {M_J, M_JAL};
    e.rjmp = m inside {M_JR, M_JALR};
    e.lnk  = m inside {M_JAL, M_BLTZAL, M_BGEZAL};
    e.dst  = m inside {M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_ADDU, M_SUBU,
                       M_AND, M_OR, M_XOR, M_NOR, M_SLT, M_SLTU, M_JALR};
    e.wr_reg = e.dst | e.lnk | e.ld |
               (m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI});
    e.m2r  = (m == M_LW);
    case (m)
      M_LWL: e.ext = 3'b001; M_LWR: e.ext = 3'b010; M_LHU: e.ext = 3'b100;
      M_LH:  e.ext = 3'b101; M_LBU: e.ext = 3'b110; M_LB:  e.ext = 3'b111;
      default: e.ext = 3'b000;
    endcase
    if (m inside {M_LB, M_LBU, M_SB})
      e.lanes = {e.res[1:0] == 2'd3, e.res[1:0] == 2'd2, e.res[1:0] == 2'd1, e.res[1:0] == 2'd0};
    else if (m inside {M_LH, M_LHU, M_SH})
      e.lanes = e.res[1] ? 4'b1100 : 4'b0011;
    else if (e.ld | e.st)
      e.lanes = 4'b1111;
    else
      e.lanes = 4'b0000;
    e.zero_chk = e.br | e.res_chk;
    case (m)
      M_BEQ:              e.zero = (a == b);
      M_BNE:              e.zero = (a != b);
      M_BLEZ:             e.zero = (sa <= 0);
      M_BGTZ:             e.zero = (sa > 0);
      M_BLTZ, M_BLTZAL:   e.zero = (sa < 0);
      M_BGEZ, M_BGEZAL:   e.zero = (sa >= 0);
      default:            e.zero = (e.res == 32'd0);
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s/%s: got %h expected %h (instr %h)", cur_tag, nm, act, want, instr);
    end
  endtask

  // Full comparison of every output against the model for the current state.
  task automatic compare_all();
    exp_t e;
    logic fe, de, e1, e2, wr;
    e  = model(instr, rs_data, rt_data);
    fe = (exp_st == 1); de = (exp_st == 2); e1 = (exp_st == 3); e2 = (exp_st == 4);
    wr = waitrequest;
    chk("state", 32'(state), 32'(exp_st));
    chk("mem_read", 32'(mem_read), 32'(fe | (e2 & e.ld)));
    chk("mem_write", 32'(mem_write), 32'(e1 & e.st));
    chk("byteenable", 32'(byteenable),
        fe ? 32'hF : (((e1 & e.st) | (e2 & e.ld)) ? 32'(e.lanes) : 32'h0));
    chk("ir_write", 32'(ir_write), 32'(de & ~wr));
    chk("pc_write", 32'(pc_write), 32'(e2 & ~wr));
    chk("reg_write", 32'(reg_write), 32'(e2 & ~wr & e.wr_reg));
    chk("pc_to_addr", 32'(pc_to_addr), 32'(fe));
    chk("ctl", {24'd0, reg_dst, link, mem_to_reg, branch, jump, reg_to_jump, 2'b00},
        {24'd0, e.dst, e.lnk, e.m2r, e.br, e.jmp, e.rjmp, 2'b00});
    chk("ext_op", 32'(ext_op), 32'(e.ext));
    if (e.res_chk)  chk("alu_result", alu_result, e.res);
    if (e.zero_chk) chk("zero", 32'(zero), 32'(e.zero));
  endtask

  task automatic step(input logic next_wr);
    @(posedge clk);
    if (!reset)            exp_st = 0;
    else if (!waitrequest) exp_st = (exp_st == 4) ? 1 : exp_st + 1;
    #1;
    waitrequest = next_wr;
    #1;
    compare_all();
  endtask

  task automatic advance_to(input int target);
    for (int n = 0; n < 8 && exp_st != target; n++) step(1'b0);
    if (exp_st != target) begin
      n_bad++;
      $display("FAIL %s/advance: state %0d never reached", cur_tag, target);
    end
  endtask

  typedef struct {
    string       nm;
    logic [31:0] ins, a, b, res;
    logic        res_chk, z;
  } tv_t;

  tv_t tv [15];

  logic [5:0] ops [28] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04,
                           6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                           6'h0E, 6'h0F, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                           6'h26, 6'h28, 6'h29, 6'h2B};
  logic [5:0] fns [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                           6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
  logic [4:0] rts [4]  = '{5'h00, 5'h01, 5'h10, 5'h11};

  initial begin
    tv[0]  = '{"slt",   32'h0000002A, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0};
    tv[1]  = '{"sltu",  32'h0000002B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    tv[2]  = '{"sra",   32'h00000103, 32'h00000000, 32'h80000000, 32'hF8000000, 1'b1, 1'b0};
    tv[3]  = '{"addu",  32'h00000021, 32'h00000005, 32'h00000007, 32'h0000000C, 1'b1, 1'b0};
    tv[4]  = '{"subu",  32'h00000023, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b1, 1'b0};
    tv[5]  = '{"nor",   32'h00000027, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0};
    tv[6]  = '{"sllv",  32'h00000004, 32'h00000004, 32'h00000001, 32'h00000010, 1'b1, 1'b0};
    tv[7]  = '{"addiu", 32'h24000001, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b1};
    tv[8]  = '{"sltiu", 32'h2C00FFFF, 32'h00000005, 32'h00000000, 32'h00000001, 1'b1, 1'b0};
    tv[9]  = '{"ori",   32'h34008000, 32'h00000000, 32'h00000000, 32'h00008000, 1'b1, 1'b0};
    tv[10] = '{"lui",   32'h3C001234, 32'h00000000, 32'h00000000, 32'h12340000, 1'b1, 1'b0};
    tv[11] = '{"blez0", 32'h18000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1};
    tv[12] = '{"bgtz0", 32'h1C000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0};
    tv[13] = '{"lw",    32'h8C00FFFC, 32'h00000100, 32'h00000000, 32'h000000FC, 1'b1, 1'b0};
    tv[14] = '{"srl31", 32'h000007C2, 32'h00000000, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0};

    reset = 1'b0; waitrequest = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
    #3;
    cur_tag = "reset";
    compare_all();
    step(1'b0);
    step(1'b0);

    // Directed ALU table, applied while held in HALT.
    for (int k = 0; k < 15; k++) begin
      cur_tag = tv[k].nm;
      instr = tv[k].ins; rs_data = tv[k].a; rt_data = tv[k].b;
      #1;
      if (tv[k].res_chk) chk("alu_result", alu_result, tv[k].res);
      chk("zero", 32'(zero), 32'(tv[k].z));
      compare_all();
    end

    // Release reset: expect 1,2,3,4,1.
    cur_tag = "seq";
    instr = 32'h00000021;
    reset = 1'b1;
    step(1'b0);
    chk("st0", 32'(state), 32'd1);
    chk("fetch_rd", 32'(mem_read), 32'd1);
    chk("fetch_pc", 32'(pc_to_addr), 32'd1);
    chk("fetch_be", 32'(byteenable), 32'hF);
    step(1'b0); chk("st1", 32'(state), 32'd2);
    step(1'b0); chk("st2", 32'(state), 32'd3);
    step(1'b0); chk("st3", 32'(state), 32'd4);
    step(1'b0); chk("st4", 32'(state), 32'd1);

    // Stall during EXEC2 of ADDU.
    cur_tag = "stall";
    instr = 32'h00000021; rs_data = 32'd5; rt_data = 32'd7;
    advance_to(4);
    waitrequest = 1'b1;
    #1;
    chk("rw_stalled", 32'(reg_write), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      chk("st_hold", 32'(state), 32'd4);
      chk("rw_hold", 32'(reg_write), 32'd0);
    end
    waitrequest = 1'b0;
    #1;
    chk("rw_release", 32'(reg_write), 32'd1);
    chk("sum", alu_result, 32'd12);
    step(1'b0);
    chk("st_after", 32'(state), 32'd1);

    // Sub-word store lanes.
    cur_tag = "sb";
    instr = 32'hA0000000; rs_data = 32'h00001003; rt_data = 32'h000000AB;
    advance_to(3);
    chk("sb_wr", 32'(mem_write), 32'd1);
    chk("sb_be", 32'(byteenable), 32'h8);
    advance_to(1);
    cur_tag = "sh";
    instr = 32'hA4000000; rs_data = 32'h00001002;
    advance_to(3);
    chk("sh_be", 32'(byteenable), 32'hC);
    advance_to(1);

    // Linking branch and BEQ.
    cur_tag = "bgezal";
    instr = 32'h04110000; rs_data = 32'hFFFFFFF0;
    advance_to(4);
    chk("bz", 32'(zero), 32'd0);
    chk("blink", 32'(link), 32'd1);
    chk("brw", 32'(reg_write), 32'd1);
    advance_to(1);
    cur_tag = "beq";
    instr = 32'h10000000; rs_data = 32'h55; rt_data = 32'h55;
    advance_to(4);
    chk("beqz", 32'(zero), 32'd1);
    chk("beqrw", 32'(reg_write), 32'd0);
    advance_to(1);

    // Randomized instructions with random stalls.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] ins;
      cur_tag = "rand";
      if ($urandom_range(0, 9) == 0) begin
        ins = $urandom;
      end else begin
        ins = {ops[$urandom_range(0, 27)], 26'($urandom)};
        if (ins[31:26] == 6'h00)
          ins[5:0] = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 15)];
        if (ins[31:26] == 6'h01)
          ins[20:16] = ($urandom_range(0, 5) == 0) ? 5'($urandom) : rts[$urandom_range(0, 3)];
      end
      instr = ins;
      case ($urandom_range(0, 3))
        0: begin rs_data = $urandom; rt_data = $urandom; end
        1: begin rs_data = $urandom; rt_data = rs_data; end
        2: begin rs_data = 32'd0; rt_data = $urandom; end
        default: begin rs_data = 32'($urandom_range(0, 3)) - 32'd2; rt_data = 32'($urandom_range(0, 3)); end
      endcase
      #1;
      compare_all();
      for (int n = 0; n < 40; n++) begin
        step((n < 20) ? ($urandom_range(0, 3) == 0) : 1'b0);
        if (exp_st == 1) break;
      end
      if (exp_st != 1) begin
        n_bad++;
        $display("FAIL rand/loop: instruction did not return to FETCH");
      end
    end

    // Reset during EXEC1 of SW.
    cur_tag = "rst_mid";
    waitrequest = 1'b0;
    instr = 32'hAC000000; rs_data = 32'h00002000; rt_data = 32'h12345678;
    advance_to(3);
    chk("sw_wr", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b0;
    exp_st = 0;
    #1;
    chk("rst_st", 32'(state), 32'd0);
    chk("rst_wr", 32'(mem_write), 32'd0);
    chk("rst_be", 32'(byteenable), 32'd0);
    compare_all();
    step(1'b0);
    chk("rst_hold", 32'(state), 32'd0);
    reset = 1'b1;
    step(1'b0);
    chk("rst_fetch", 32'(state), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_exec_ctrl.md
MIPS_EXEC_CTRL -- requirements
Module: mips_exec_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 forces state HALT immediately.
REQ-003 waitrequest  in  1  Avalon stall; 1 freezes state and suppresses register, PC and IR write enables.
REQ-004 instr  in  32  current instruction (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0]).
REQ-005 rs_data  in  32  register-file read port 1; ALU operand A.
REQ-006 rt_data  in  32  register-file read port 2.
REQ-007 state  out  3  0 HALT, 1 FETCH, 2 DECODE, 3 EXEC1, 4 EXEC2.
REQ-008 mem_read, mem_write  out  1 each  Avalon read and write strobes.
REQ-009 byteenable  out  4  Avalon byte lanes.
REQ-010 ir_write, pc_write, reg_write  out  1 each  write enables, all gated by !waitrequest.
REQ-011 pc_to_addr  out  1  1 selects PC as the bus address; 0 selects alu_result.
REQ-012 reg_dst, link, mem_to_reg  out  1 each  destination rd (reg_dst=1), rt (reg_dst=0), or $31 (link=1); mem_to_reg selects the full load word.
REQ-013 branch, jump, reg_to_jump  out  1 each  branch, J/JAL, and JR/JALR indicators.
REQ-014 ext_op  out  3  load format: 000 none, 001 LWL, 010 LWR, 100 LHU, 101 LH, 110 LBU, 111 LB.
REQ-015 alu_result  out  32  ALU output.
REQ-016 zero  out  1  branch-taken for branches; otherwise (alu_result==0).

Function
REQ-017 State sequencing: HALT->FETCH->DECODE->EXEC1->EXEC2->FETCH; each transition occurs only on an edge with waitrequest=0.
REQ-018 In FETCH: pc_to_addr=1, mem_read=1, byteenable=1111.
REQ-019 In DECODE: ir_write=1.
REQ-020 In EXEC1: stores drive mem_write=1.
REQ-021 In EXEC2: loads drive mem_read=1; reg_write is asserted for register-writing instructions; pc_write=1.
REQ-022 In all other states, and in HALT, all strobes are 0 and byteenable=0000.
REQ-023 Byte lane address: addr_lo = alu_result[1:0].
REQ-024 Byte lanes for SB/LB/LBU: 0001<<addr_lo.
REQ-025 Byte lanes for SH/LH/LHU: 1100 if addr_lo[1] else 0011.
REQ-026 Byte lanes for SW/LW/LWL/LWR: 1111.
REQ-027 ALU operand B is selected as follows:
- rt_data for R-type and BEQ/BNE.
- Sign-extended imm for ADDIU, SLTI, SLTIU, and all loads and stores.
- Zero-extended imm for ANDI, ORI and XORI.
REQ-028 R-type funct: 00 SLL, 02 SRL, 03 SRA (use shamt), 04 SLLV, 06 SRLV, 07 SRAV (use rs_data[4:0]), 08 JR, 09 JALR, 21 ADDU, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT, 2B SLTU.
REQ-029 I/J opcodes: 01 REGIMM (rt 00 BLTZ, 01 BGEZ, 10 BLTZAL, 11 BGEZAL), 02 J, 03 JAL, 04 BEQ, 05 BNE, 06 BLEZ, 07 BGTZ, 09 ADDIU, 0A SLTI, 0B SLTIU, 0C ANDI, 0D ORI, 0E XORI, 0F LUI.
REQ-030 Load and store opcodes: 20 LB, 21 LH, 22 LWL, 23 LW, 24 LBU, 25 LHU, 26 LWR, 28 SB, 29 SH, 2B SW.
REQ-031 ALU arithmetic and width rules:
- Add and subtract are modulo 2^32 with no overflow trap.
- SLT and SLTI compare as signed; SLTU and SLTIU compare as unsigned.
- Set results are 0 or 1.
- Shifts operate on rt_data.
- LUI result is imm<<16.
REQ-032 Loads and stores: alu_result = rs_data + sign-extended imm.
REQ-033 Branch conditions drive zero as follows:
- BEQ: a==b; BNE: a!=b.
- BLEZ: signed a<=0; BGTZ: signed a>0.
- BLTZ and BLTZAL: a<0; BGEZ and BGEZAL: a>=0.
REQ-034 reg_write applies to:
- R-type ALU operations and JALR (reg_dst=1).
- I-type ALU operations, LUI and loads (reg_dst=0).
- JAL, BLTZAL and BGEZAL (link=1), written regardless of the branch outcome.
REQ-035 mem_to_reg=1 only for LW; loads other than LW set ext_op per REQ-014.
REQ-036 Unrecognised opcodes and functs produce no reg_write and no memory strobe; they still sequence through the states.
REQ-037 All outputs except state are combinational from state, instr, rs_data, rt_data and waitrequest.

Reset
REQ-038 reset=0 asynchronously sets state=HALT; all strobes are 0 while in HALT.
REQ-039 After reset returns to 1, the first edge with waitrequest=0 moves HALT to FETCH.
REQ-040 Reset mid-instruction aborts the instruction with no further writes.

Verification
REQ-041 Release reset, waitrequest=0: state sequence 0,1,2,3,4,1; FETCH shows mem_read=1, pc_to_addr=1, byteenable=1111.
REQ-042 Hold waitrequest=1 during EXEC2 of ADDU (rs=5, rt=7): state stays 4, reg_write=0; on release, reg_write=1 and alu_result=12.
REQ-043 SB with rs=0x1003, imm=0 in EXEC1: mem_write=1, byteenable=1000; with SH and rs=0x1002: byteenable=1100.
REQ-044 SLT with a=0xFFFFFFFF, b=1 gives 1; SLTU gives 0; SRA of 0x80000000 with shamt=4 gives 0xF8000000.
REQ-045 BGEZAL with a=0xFFFFFFF0: zero=0, link=1, reg_write=1 in EXEC2; BEQ with a==b: zero=1, reg_write=0.
REQ-046 Assert reset=0 during EXEC1 of SW: state=0 immediately, mem_write=0 before the next edge.
